// File: rtl/sargantana_icache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// sargantana_icache_fill_ctrl
//
// Miss-refill and flush sequencer that sits directly in front of the icache
// tag/data memory top. It takes one miss (tag + set index) at a time and
// fetches the line from L2. It then picks a victim way and writes tag, valid
// bit and line into the arrays in a single cycle. It also sequences a
// whole-cache flush. This block is the only driver of the arrays' write-side
// request, enable and data inputs.
//
// Configuration macro:
//   ICACHE_FILL_LFSR_REPL_EN
//     Defined   : the replacement policy uses an 8-bit Galois LFSR
//                 (taps 8'hB8, seed 8'h01) that advances every cycle.
//     Undefined : the replacement policy uses a round-robin pointer.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   miss_valid_i/ready_o     miss handshake
//   miss_tag_i/idx_i         address of the missing line
//   miss_vbits_i             valid bits of the target set at acceptance
//   flush_i                  flush request (level)
//   l2_req_valid_o/ready_i   L2 line request handshake
//   l2_req_addr_o            {tag, idx} of the requested line
//   l2_resp_valid_i/data_i   L2 line return (always accepted)
//   tag_req_o, data_req_o    array way selects
//   tag_we_o, data_we_o      array write enables
//   flush_en_o               invalidate all valid bits
//   valid_bit_o, tag_o,
//   cline_o, addr_o          array write data and set index
//   fill_done_o, fill_way_o  line-written pulse and the way written
//   flush_done_o             flush-issued pulse
//   busy_o                   sequencer not idle
// -----------------------------------------------------------------------------
// state  | meaning
// IDLE   | ready for a miss; a flush request wins over a miss
// REQ    | presenting the line request to L2
// WAIT   | request accepted, waiting for the line
// WRITE  | one-cycle tag/valid/line write into the victim way
// FLUSH  | one-cycle invalidate of every way
// -----------------------------------------------------------------------------
module sargantana_icache_fill_ctrl #(
    parameter int ICACHE_N_WAY = 4,
    parameter int SET_WIDHT    = 256,
    parameter int TAG_WIDHT    = 20,
    parameter int ADDR_WIDHT   = 6
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              miss_valid_i,
    output logic                              miss_ready_o,
    input  logic [TAG_WIDHT-1:0]              miss_tag_i,
    input  logic [ADDR_WIDHT-1:0]             miss_idx_i,
    input  logic [ICACHE_N_WAY-1:0]           miss_vbits_i,
    input  logic                              flush_i,
    output logic                              l2_req_valid_o,
    input  logic                              l2_req_ready_i,
    output logic [TAG_WIDHT+ADDR_WIDHT-1:0]   l2_req_addr_o,
    input  logic                              l2_resp_valid_i,
    input  logic [SET_WIDHT-1:0]              l2_resp_data_i,
    output logic [ICACHE_N_WAY-1:0]           tag_req_o,
    output logic [ICACHE_N_WAY-1:0]           data_req_o,
    output logic                              tag_we_o,
    output logic                              data_we_o,
    output logic                              flush_en_o,
    output logic                              valid_bit_o,
    output logic [TAG_WIDHT-1:0]              tag_o,
    output logic [SET_WIDHT-1:0]              cline_o,
    output logic [ADDR_WIDHT-1:0]             addr_o,
    output logic                              fill_done_o,
    output logic [$clog2(ICACHE_N_WAY)-1:0]   fill_way_o,
    output logic                              flush_done_o,
    output logic                              busy_o
);

    localparam int WAY_W = $clog2(ICACHE_N_WAY);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_FLUSH = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [TAG_WIDHT-1:0]    r_tag;
    logic [ADDR_WIDHT-1:0]   r_idx;
    logic [SET_WIDHT-1:0]    r_line;
    logic [WAY_W-1:0]        r_way;
    logic                    r_kill;

    logic                    w_accept;
    logic                    w_has_free;
    logic [WAY_W-1:0]        w_free_way;
    logic [WAY_W-1:0]        w_policy_way;
    logic [WAY_W-1:0]        w_victim;
    logic [ICACHE_N_WAY-1:0] w_onehot;
    logic                    w_in_write;
    logic                    w_in_flush;
    logic                    w_kill_now;

    assign miss_ready_o = (r_state == ST_IDLE) && !flush_i;
    assign w_accept     = miss_valid_i && miss_ready_o;

    // A flush arriving in the same cycle as the L2 response must still
    // suppress the write, so the registered kill flag is not enough here.
    assign w_kill_now   = r_kill || flush_i;

    // ------------------------------------------------------------------
    // Victim selection: an invalid way always wins over the policy.
    // ------------------------------------------------------------------
    assign w_has_free = ~(&miss_vbits_i);

    // Scan from the top down so the lowest invalid way is the last one
    // written and therefore the one selected.
    always_comb begin
        w_free_way = '0;
        for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
            if (!miss_vbits_i[i]) begin
                w_free_way = WAY_W'(i);
            end
        end
    end

`ifdef ICACHE_FILL_LFSR_REPL_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_lfsr <= 8'h01;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
        end
    end

    assign w_policy_way = r_lfsr[WAY_W-1:0];
`else
    logic [WAY_W-1:0] r_rr_ptr;

    // Only advances when the policy actually chose the victim; ways are a
    // power of two so the natural wrap takes N-1 back to 0.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rr_ptr <= '0;
        end else if (w_accept && !w_has_free) begin
            r_rr_ptr <= r_rr_ptr + WAY_W'(1);
        end
    end

    assign w_policy_way = r_rr_ptr;
`endif

    assign w_victim = w_has_free ? w_free_way : w_policy_way;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (flush_i) begin
                    w_state_nxt = ST_FLUSH;
                end else if (miss_valid_i) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (l2_req_ready_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (l2_resp_valid_i) begin
                    w_state_nxt = w_kill_now ? ST_FLUSH : ST_WRITE;
                end
            end
            ST_WRITE: w_state_nxt = ST_IDLE;
            ST_FLUSH: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_kill <= 1'b0;
        end else if (w_state_nxt == ST_FLUSH) begin
            r_kill <= 1'b0;
        end else if (flush_i && ((r_state == ST_REQ) || (r_state == ST_WAIT))) begin
            r_kill <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_tag <= '0;
            r_idx <= '0;
            r_way <= '0;
        end else if (w_accept) begin
            r_tag <= miss_tag_i;
            r_idx <= miss_idx_i;
            r_way <= w_victim;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_line <= '0;
        end else if ((r_state == ST_WAIT) && l2_resp_valid_i && !w_kill_now) begin
            r_line <= l2_resp_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Write-side signals are forced to zero outside WRITE/FLUSH
    // so the arrays never see stale data on their write ports.
    // ------------------------------------------------------------------
    assign w_in_write = (r_state == ST_WRITE);
    assign w_in_flush = (r_state == ST_FLUSH);
    assign w_onehot   = ICACHE_N_WAY'(1) << r_way;

    assign l2_req_valid_o = (r_state == ST_REQ);
    assign l2_req_addr_o  = l2_req_valid_o ? {r_tag, r_idx} : '0;

    assign tag_req_o   = w_in_flush ? {ICACHE_N_WAY{1'b1}} :
                         (w_in_write ? w_onehot : '0);
    assign data_req_o  = w_in_write ? w_onehot : '0;
    assign tag_we_o    = w_in_write;
    assign data_we_o   = w_in_write;
    assign valid_bit_o = w_in_write;
    assign tag_o       = w_in_write ? r_tag  : '0;
    assign cline_o     = w_in_write ? r_line : '0;
    assign addr_o      = w_in_write ? r_idx  : '0;
    assign fill_done_o = w_in_write;
    assign fill_way_o  = w_in_write ? r_way  : '0;

    assign flush_en_o   = w_in_flush;
    assign flush_done_o = w_in_flush;

    assign busy_o = (r_state != ST_IDLE);

endmodule
